// File: rtl/instruction_memory_loadable_if.sv
// ----------------------------------------------------------------------------
// instruction_memory_loadable_if
// Fetch bus between the processor fetch stage (master) and the loadable
// instruction memory (slave).
//   req_valid / req_ready / req_addr : byte-addressed fetch request handshake
//   rsp_valid / rsp_ready            : response handshake
//   rsp_data                         : fetched instruction word
//   rsp_fault                        : 00 ok, 01 misaligned, 10 out of range,
//                                      11 uninitialised word
// ----------------------------------------------------------------------------
interface instruction_memory_loadable_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 18
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_fault;
    logic              rsp_ready;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_fault,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_fault,
        input  rsp_ready
    );
endinterface

// File: rtl/instruction_memory_loadable.sv
// ----------------------------------------------------------------------------
// instruction_memory_loadable
// DEPTH x DATA_W instruction store, filled through a boot-time load port and
// then read by the fetch stage through a valid/ready bus with a one-cycle
// registered response carrying a fault code.
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        synchronous active-low reset (back to BOOT)
//   i_ld_we        load write strobe, honoured in BOOT only
//   i_ld_addr      load word index
//   i_ld_data      load word
//   i_ld_done      end-of-load pulse, BOOT -> RUN
//   o_ld_err       sticky: a load targeted an index >= DEPTH
//   o_words_loaded saturating count of accepted load writes
//   o_running      high in RUN
//   bus            fetch request/response bus (slave side)
// ----------------------------------------------------------------------------
module instruction_memory_loadable #(
    parameter int                DATA_W   = 18,
    parameter int                ADDR_W   = 18,
    parameter int                DEPTH    = 128,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_ld_we,
    input  logic [$clog2(DEPTH):0]     i_ld_addr,
    input  logic [DATA_W-1:0]          i_ld_data,
    input  logic                       i_ld_done,
    output logic                       o_ld_err,
    output logic [$clog2(DEPTH):0]     o_words_loaded,
    output logic                       o_running,
    instruction_memory_loadable_if.slave bus
);
    localparam int AW = $clog2(DEPTH);      // storage index width
    localparam int LW = AW + 1;             // load index / counter width
    localparam int IW = ADDR_W - 2;         // fetch word index width

    // DEPTH expressed in the widths it is compared against; the fetch side
    // gets one spare bit so DEPTH == 2**IW still fits.
    localparam logic [LW-1:0] DEPTH_LD = LW'(DEPTH);
    localparam logic [IW:0]   DEPTH_RQ = (IW + 1)'(DEPTH);
    localparam logic [LW-1:0] CNT_MAX  = {LW{1'b1}};

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_written;
    logic [LW-1:0]     r_words_loaded;
    logic              r_ld_err;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_fault;

    logic              w_ld_hit;
    logic              w_ld_miss;
    logic [AW-1:0]     w_ld_idx;
    logic              w_running;
    logic              w_accept;
    logic [IW-1:0]     w_req_idx;
    logic [AW-1:0]     w_mem_idx;
    logic [1:0]        w_fault;
    logic [DATA_W-1:0] w_rd_data;

    assign w_ld_idx  = i_ld_addr[AW-1:0];
    assign w_running = (r_state == ST_RUN);
    assign w_req_idx = bus.req_addr[ADDR_W-1:2];
    assign w_mem_idx = w_req_idx[AW-1:0];

    // A held response blocks new requests until the consumer takes it.
    assign bus.req_ready = w_running && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept      = bus.req_valid && bus.req_ready;

    // Next-state and load decode: loads only matter in BOOT.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_hit    = 1'b0;
        w_ld_miss   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                if (i_ld_we) begin
                    if (i_ld_addr < DEPTH_LD) begin
                        w_ld_hit = 1'b1;
                    end else begin
                        w_ld_miss = 1'b1;
                    end
                end else begin
                    w_ld_hit  = 1'b0;
                    w_ld_miss = 1'b0;
                end
                // A write in the ld_done cycle still lands before RUN.
                if (i_ld_done) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_BOOT;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // State register; RUN is only left through reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load bookkeeping: written bits, saturating load counter, sticky error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_written      <= {DEPTH{1'b0}};
            r_words_loaded <= {LW{1'b0}};
            r_ld_err       <= 1'b0;
        end else begin
            if (w_ld_hit) begin
                r_written[w_ld_idx] <= 1'b1;
                if (r_words_loaded != CNT_MAX) begin
                    r_words_loaded <= r_words_loaded + LW'(1);
                end
            end
            if (w_ld_miss) begin
                r_ld_err <= 1'b1;
            end
        end
    end

    // Word storage; contents survive reset, validity is tracked by r_written.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_ld_hit) begin
            r_mem[w_ld_idx] <= i_ld_data;
        end
    end

    // Fault classification in priority order; any fault yields NOP_WORD.
    always_comb begin
        w_fault   = 2'b00;
        w_rd_data = NOP_WORD;
        if (bus.req_addr[1:0] != 2'b00) begin
            w_fault = 2'b01;
        end else if ({1'b0, w_req_idx} >= DEPTH_RQ) begin
            w_fault = 2'b10;
        end else if (!r_written[w_mem_idx]) begin
            w_fault = 2'b11;
        end else begin
            w_fault   = 2'b00;
            w_rd_data = r_mem[w_mem_idx];
        end
    end

    // Single-entry response register: load on accept, drop when consumed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= NOP_WORD;
            r_rsp_fault <= 2'b00;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_fault <= w_fault;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_fault  = r_rsp_fault;
    assign o_ld_err       = r_ld_err;
    assign o_words_loaded = r_words_loaded;
    assign o_running      = w_running;

endmodule

// File: doc/instruction_memory_loadable.md
# instruction_memory_loadable

Parametrised, loadable instruction memory for the processor's fetch stage. It stores DEPTH instruction words of DATA_W bits and is filled through a boot-time load port. It then serves byte-addressed, word-aligned fetches through a valid/ready handshake with a one-cycle registered read. Each response carries a fault code for misaligned, out-of-range or never-written addresses; a faulting fetch returns NOP_WORD.

## Interface
- DATA_W, 18: instruction word width.
- ADDR_W, 18: fetch byte-address width; word index = req_addr[ADDR_W-1:2].
- DEPTH, 128: number of instruction words; must be ≤ 2^(ADDR_W-2).
- NOP_WORD, 18'b0: word returned on any faulting fetch.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_we  in  1  load write strobe (BOOT state only).
- ld_addr  in  $clog2(DEPTH)+1  load word index.
- ld_data  in  DATA_W  load word.
- ld_done  in  1  end-of-load pulse; moves BOOT→RUN.
- ld_err  out  1  sticky: a load targeted an index ≥ DEPTH.
- words_loaded  out  $clog2(DEPTH)+1  count of accepted load writes.
- running  out  1  high in RUN state.
- req_valid  in  1  fetch request valid.
- req_addr  in  ADDR_W  fetch byte address.
- req_ready  out  1  fetch request accepted this cycle when high with req_valid.
- rsp_valid  out  1  response valid.
- rsp_data  out  DATA_W  fetched instruction.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 uninitialised.
- rsp_ready  in  1  consumer accepts response.

## Operation
- States: BOOT, entered at reset, and RUN. The only transition is BOOT→RUN, when ld_done=1 in BOOT. Leaving RUN requires reset.
- Storage: DEPTH×DATA_W array plus a per-word written bit. Written bits are cleared on reset; array contents are not.
- BOOT load:
  - ld_we=1 with ld_addr < DEPTH: writes the word, sets its written bit, increments words_loaded (saturates at 2^width−1).
  - ld_we=1 with ld_addr ≥ DEPTH: write dropped, counter unchanged, ld_err set.
  - Rewriting an index overwrites it and still increments the counter.
- ld_we and ld_done in the same BOOT cycle: the write is performed, then the block enters RUN.
- In RUN, ld_we and ld_done are ignored.
- Fetches are accepted only in RUN. req_ready = running && (!rsp_valid || rsp_ready).
- Fault priority on an accepted request, highest first:
  - misaligned: req_addr[1:0] ≠ 0.
  - out of range: req_addr[ADDR_W-1:2] ≥ DEPTH.
  - uninitialised: written bit clear.
  - ok: none of the above.
- Any fault: rsp_data = NOP_WORD. Ok: rsp_data = stored word.
- Response register, single entry:
  - Loads on acceptance.
  - Holds rsp_data and rsp_fault stable while rsp_valid && !rsp_ready.
  - Clears rsp_valid when rsp_ready=1 and no new request is accepted that cycle.

## Timing
- Reset (rst=0 at an edge): state BOOT, running=0, req_ready=0, rsp_valid=0, rsp_data=NOP_WORD, rsp_fault=00, ld_err=0, words_loaded=0. Reset mid-transaction discards any pending response.
- running rises on the edge after the ld_done cycle. req_ready can be high in that first RUN cycle.
- Fetch latency is 1 cycle: request accepted at edge N → rsp_valid, rsp_data and rsp_fault valid after edge N.
- Full throughput: back-to-back requests with rsp_ready=1 give one response per cycle.
- Backpressure: with rsp_valid=1 and rsp_ready=0, req_ready=0 combinationally and the response does not change.
- With rsp_valid=1 and rsp_ready=1, a simultaneously accepted request replaces the response at the next edge and rsp_valid stays 1.
- A load write at edge N is visible to any fetch accepted at or after the RUN transition; there is no read-during-write hazard because load and fetch are exclusive.

## Test plan
- Reset with rst=0 for 2 cycles → all outputs at reset values. In BOOT, req_valid=1 with addr 0 → req_ready=0 and no response.
- Load words 0..8 = 0x08F20, 0x08F20, 0x08F20, 0x08010, 0x03EE0, 0x040ED, 0x30000, 0x17FDC, 0x040ED; then ld_done → words_loaded=9, running=1. Fetch byte addresses 0,4,...,32 back-to-back with rsp_ready=1 → one response per cycle in order, fault=00.
- Fetch 0x00006 → rsp_data=NOP_WORD, fault=01. Fetch 4·DEPTH → fault=10. Fetch 4·9 (never written) → fault=11.
- Load ld_addr=DEPTH in BOOT → ld_err=1, words_loaded unchanged. ld_err stays 1 through RUN until reset.
- Fetch addr 12 with rsp_ready=0 for 3 cycles → rsp_data=0x08010 held stable and req_ready=0. Raise rsp_ready together with a new request at addr 16 → next cycle rsp_data=0x03EE0.
- In RUN, drive ld_we to index 0 with 0x3FFFF → fetch addr 0 still returns 0x08F20. Assert rst mid-stream → rsp_valid=0 and state BOOT. Fetch after the next ld_done with no reload → fault=11.
